// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one operand bit per cycle through an external full-adder cell.
// Latency: done pulses WIDTH cycles after the accepting edge (RUN = WIDTH cycles, then one DONE cycle).
// Backpressure: ready is low outside IDLE; start is dropped, not queued, while ready=0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pall,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_prop,
  input  logic             fa_gen,
  input  logic             fa_sout
);

  // One extra bit so the index can reach WIDTH without wrapping.
  localparam int IDX_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             carry_nxt;
  logic             last_bit;

  // Carry comes only from the cell's propagate/generate, never from a local a&b.
  assign carry_nxt = fa_gen | (fa_prop & carry);
  assign last_bit  = (idx == IDX_W'(WIDTH - 1));

  // Cell inputs are the current operand LSBs and carry, forced low outside RUN.
  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & carry;

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      pall  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
            pall  <= 1'b1;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {fa_sout, sum[WIDTH-1:1]};
          carry <= carry_nxt;
          pall  <= pall & fa_prop;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          idx   <= idx + IDX_W'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB on this edge.
            cout  <= carry_nxt;
            ovf   <= carry_nxt ^ carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed operand vectors, full-adder cell modelled in the bench.
// Expected results are pushed at acceptance and popped by a monitor on each done pulse.
// Also covers reset values, mid-run abort, rst/start collision and start held high.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready, busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, pall;
  logic             fa_a, fa_b, fa_cin;
  logic             fa_prop, fa_gen, fa_sout;

  // Full-adder cell model.
  assign fa_prop = fa_a ^ fa_b;
  assign fa_gen  = fa_a & fa_b;
  assign fa_sout = fa_a ^ fa_b ^ fa_cin;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf), .pall(pall),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_prop(fa_prop), .fa_gen(fa_gen), .fa_sout(fa_sout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             pall;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   overlap = 0;
  int   last_done = -1;
  bit   b2b = 1'b0;
  int   d0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one scoreboard pop per done pulse; latency counted from the
  // cycle start was presented (accepting cycle = 0) to the done cycle.
  always @(negedge clk) begin
    if (ready && busy) overlap++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done seen with no operation outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        check("pall", pall, e.pall);
        check("latency", cyc - e.acc, WIDTH + 1);
        if (b2b && last_done >= 0) check("done_period", cyc - last_done, WIDTH + 2);
        last_done = cyc;
      end
    end
  end

  // Issue one operation at a negedge; operands are scrambled after acceptance.
  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eo, input logic ep);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready got 0, expected 1 within 50 cycles");
      return;
    end
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo, pall: ep, acc: cyc});
    @(negedge clk);
    start = 1'b0;
    a = ~va;
    b = ~vb;
    cin = ~vc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sum"}, sum, '0);
    check({tag, "_flags"}, {cout, ovf, pall}, 3'b000);
    check({tag, "_fa"}, {fa_a, fa_b, fa_cin}, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // rst and start together: reset wins, start is not remembered.
    rst = 1'b1;
    start = 1'b1;
    a = 8'h11;
    b = 8'h22;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 1'b0);
    @(negedge clk);
    check("rst_start_dropped", busy, 1'b0);
    check("rst_start_ready", ready, 1'b1);

    // 0x35+0x4A: bit 7 has a=b=0, so the propagate chain breaks there.
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_sum", sum, 8'h7F);
    check("hold_flags", {cout, ovf, pall}, 3'b000);

    issue(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    wait_idle();
    issue(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    wait_idle();
    issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // 0x80+0x80 with a stray start pulse in the middle of RUN.
    d0 = done_cnt;
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    // Abort an operation with reset during RUN; no result may surface.
    a = 8'h99;
    b = 8'h77;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort");
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // start held high: back-to-back operations, one per 10 cycles.
    d0 = done_cnt;
    b2b = 1'b1;
    last_done = -1;
    a = 8'h21;
    b = 8'h13;
    cin = 1'b1;
    for (int i = 0; i < 30; i++) begin
      start = 1'b1;
      if (ready) exp_q.push_back('{sum: 8'h35, cout: 1'b0, ovf: 1'b0, pall: 1'b0, acc: cyc});
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    b2b = 1'b0;
    check("b2b_done_count", done_cnt - d0, 3);
    check("ready_busy_overlap", overlap, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
